hififo_fpc_fifo: RTL

From-PC DMA engine that pairs with the to-PC write path. Walks a host buffer through a 32-entry page table of 2 MiB pages and issues 128-byte memory read requests. Accepts in-order 64-bit completion data into an internal FIFO, and presents that FIFO to user logic with a first-word-fall-through valid/read interface on the same clock. Host software controls the engine through PIO registers: stop pointer, interrupt pointer and page table.

---
 rtl/hififo_fpc_fifo.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hififo_fpc_fifo.sv
// From-PC DMA read engine: page-table address walk, credit-limited 128-byte read
// requests, completion FIFO with FWFT read port. Optional HIFIFO_FPC_OVERFLOW_FLAG_EN adds a sticky overflow flag on status[31].
module hififo_fpc_fifo #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        interrupt,
    output logic [31:0] status,
    input  logic        pio_wvalid,
    input  logic [63:0] pio_wdata,
    input  logic [12:0] pio_addr,
    output logic        rd_valid,
    output logic [63:0] rd_addr,
    input  logic        rd_ready,
    input  logic        rx_valid,
    input  logic [63:0] rx_data,
    input  logic        fifo_read,
    output logic [63:0] fifo_data,
    output logic        fifo_valid
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int SW    = DEPTH_LOG2 + 3;

    logic [42:0]           pt [32];
    logic [63:0]           mem [DEPTH];
    logic [18:0]           p_req;
    logic [18:0]           p_stop;
    logic [18:0]           p_int;
    logic [22:0]           p_in;
    logic [18:0]           p_done;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         fifo_count;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [SW-1:0]         credit_sum;
    logic                  credit_ok;
    logic                  accept;
    logic                  issue;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic                  pio_unused;

    assign p_done     = p_in[22:4];
    assign accept     = rd_valid && rd_ready;
    assign fifo_valid = (fifo_count != '0);
    assign fifo_data  = mem[rd_ptr];
    assign full       = (fifo_count == CW'(DEPTH));
    assign pop        = fifo_read && fifo_valid;
    assign push       = rx_valid && (!full || pop);
    assign pio_unused = ^pio_wdata[6:0];

    // Count both buffered words and words still owed by the host, so a new
    // 16-word request is only made when its data is guaranteed room.
    assign credit_sum = SW'(fifo_count) + SW'(outstanding) + SW'(16);
    assign credit_ok  = (credit_sum <= SW'(DEPTH));
    assign issue      = !rd_valid && (p_req != p_stop) && credit_ok;

    always_ff @(posedge clock) begin
        if (pio_wvalid && pio_addr[12:5] == 8'd1) begin
            pt[pio_addr[4:0]] <= pio_wdata[63:21];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_stop <= '0;
            p_int  <= '0;
        end else if (pio_wvalid) begin
            if (pio_addr == 13'd3) begin
                p_stop <= pio_wdata[25:7];
            end
            if (pio_addr == 13'd4) begin
                p_int <= pio_wdata[25:7];
            end
        end
    end

    // Address is captured when the request is raised and held until accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            p_req    <= '0;
        end else if (accept) begin
            rd_valid <= 1'b0;
            p_req    <= p_req + 19'd1;
        end else if (issue) begin
            rd_valid <= 1'b1;
            rd_addr  <= {pt[p_req[18:14]], p_req[13:0], 7'd0};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            p_in        <= '0;
        end else begin
            case ({accept, rx_valid})
                2'b10:   outstanding <= outstanding + CW'(16);
                2'b01:   outstanding <= outstanding - CW'(1);
                2'b11:   outstanding <= outstanding + CW'(15);
                default: outstanding <= outstanding;
            endcase
            if (rx_valid) begin
                p_in <= p_in + 23'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            interrupt <= 1'b0;
        end else begin
            interrupt <= (p_int == p_done);
        end
    end

`ifdef HIFIFO_FPC_OVERFLOW_FLAG_EN
    logic overflow;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (rx_valid && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    assign status = {overflow, 5'd0, p_done, 7'd0};
`else
    assign status = {6'd0, p_done, 7'd0};
`endif

endmodule
